// File: rtl/rtt_probe_gen.sv
// rtt_probe_gen
//   Emits timestamped RTT probe frames, with a module header, into the
//   data-path input of a MAC group. Each probe is 9 words: a module header,
//   then a 64-byte Ethernet frame carrying the addresses, the ethertype,
//   a 32-bit sequence number and the 64-bit launch timestamp, zero padded.
//   It supports single shots, fixed bursts and continuous trains with a
//   programmable idle gap between probes.
//
// Ports
//   clk          core clock
//   reset        asynchronous, active-low reset
//   out_data     data word to the MAC group
//   out_ctrl     control word (FF = module header, 01 = last word)
//   out_wr       word-valid strobe, only asserted when out_rdy is high
//   out_rdy      downstream can accept a word this cycle
//   count64      free-running timestamp counter
//   start        one-cycle pulse that launches a run (ignored unless idle)
//   stop         level; ends the run after the current packet
//   num_probes   probes per run, 0 = continuous
//   interval     idle cycles between probes
//   dst_mac      destination Ethernet address
//   src_mac      source Ethernet address
//   dst_port     one-hot output-port field for the module header
//   busy         high while a run is in progress
//   probes_sent  total completed probes since reset
//   last_seq     sequence number of the last completed probe
module rtt_probe_gen #(
    parameter int          DATA_WIDTH = 64,
    parameter int          CTRL_WIDTH = DATA_WIDTH / 8,
    parameter logic [15:0] SRC_PORT   = 16'h0000,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [63:0]           count64,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           num_probes,
    input  logic [31:0]           interval,
    input  logic [47:0]           dst_mac,
    input  logic [47:0]           src_mac,
    input  logic [15:0]           dst_port,
    output logic                  busy,
    output logic [31:0]           probes_sent,
    output logic [31:0]           last_seq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    localparam logic [3:0] LAST_W = 4'd8;

    // Control state (reset)
    state_t      state_q, state_d;
    logic [3:0]  w_q, w_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] seq_q, seq_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] sent_q, sent_d;
    logic [31:0] lseq_q, lseq_d;

    // Run configuration and launch timestamp (data only, not reset)
    logic [15:0] num_q;
    logic [31:0] interval_q;
    logic [47:0] dmac_q;
    logic [47:0] smac_q;
    logic [15:0] dport_q;
    logic [63:0] ts_q;

    logic cfg_load;
    logic ts_load;
    logic accept;

    assign accept = (state_q == S_SEND) && out_rdy;
    assign out_wr = accept;
    assign busy   = (state_q != S_IDLE);
    assign probes_sent = sent_q;
    assign last_seq    = lseq_q;

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        gap_d    = gap_q;
        seq_d    = seq_q;
        rem_d    = rem_q;
        sent_d   = sent_q;
        lseq_d   = lseq_q;
        cfg_load = 1'b0;
        ts_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SEND;
                    w_d      = 4'd0;
                    seq_d    = 32'd0;
                    rem_d    = num_probes;
                    cfg_load = 1'b1;
                end
            end

            S_SEND: begin
                if (out_rdy) begin
                    if (w_q == 4'd0) begin
                        ts_load = 1'b1;
                    end
                    if (w_q == LAST_W) begin
                        w_d    = 4'd0;
                        sent_d = sent_q + 32'd1;
                        lseq_d = seq_q;
                        seq_d  = seq_q + 32'd1;
                        if (rem_q != 16'd0) begin
                            rem_d = rem_q - 16'd1;
                        end
                        // A bounded run ends when the probe just finished was its last.
                        if (stop || ((num_q != 16'd0) && (rem_q == 16'd1))) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_GAP;
                            // GAP spends (counter+1) cycles, so interval N loads N-1.
                            // interval 0 still costs one GAP cycle.
                            gap_d = (interval_q == 32'd0) ? 32'd0 : (interval_q - 32'd1);
                        end
                    end else begin
                        w_d = w_q + 4'd1;
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (gap_q == 32'd0) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            w_q     <= 4'd0;
            gap_q   <= 32'd0;
            seq_q   <= 32'd0;
            rem_q   <= 16'd0;
            sent_q  <= 32'd0;
            lseq_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            gap_q   <= gap_d;
            seq_q   <= seq_d;
            rem_q   <= rem_d;
            sent_q  <= sent_d;
            lseq_q  <= lseq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_load) begin
            num_q      <= num_probes;
            interval_q <= interval;
            dmac_q     <= dst_mac;
            smac_q     <= src_mac;
            dport_q    <= dst_port;
        end
        if (ts_load) begin
            ts_q <= count64;
        end
    end

    // Word mux: purely registered fields selected by w, so the presented
    // word holds steady across any number of stalled cycles.
    always_comb begin
        out_data = '0;
        out_ctrl = '0;
        if (state_q == S_SEND) begin
            case (w_q)
                4'd0: begin
                    out_ctrl = 8'hFF;
                    out_data = {dport_q, 16'd8, SRC_PORT, 16'd64};
                end
                4'd1: out_data = {dmac_q, smac_q[47:32]};
                4'd2: out_data = {smac_q[31:0], ETHERTYPE, seq_q[31:16]};
                4'd3: out_data = {seq_q[15:0], ts_q[63:16]};
                4'd4: out_data = {ts_q[15:0], 48'h0};
                4'd8: out_ctrl = 8'h01;
                default: begin
                    out_ctrl = 8'h00;
                    out_data = '0;
                end
            endcase
        end
    end

endmodule
